// File: rtl/minv_pkg.sv
// rtl/minv_pkg.sv - shared constants, state and flag codes for the modular-inverse sequencer
package minv_pkg;

    localparam int W      = 256;
    localparam int DW     = 16;
    localparam int NWORDS = W / DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADP,
        S_LOADA,
        S_START,
        S_WAIT,
        S_UNLOAD,
        S_DONE
    } minv_seq_state_t;

    localparam logic [1:0] FLAG_X1 = 2'b00;
    localparam logic [1:0] FLAG_X2 = 2'b01;
    localparam logic [1:0] FLAG_T  = 2'b11;

endpackage

// File: rtl/minv_word_cnt.sv
// rtl/minv_word_cnt.sv - 4-bit word counter shared by the load and unload phases
module minv_word_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [3:0] o_k,
    output logic       o_last
);
    import minv_pkg::*;

    logic [3:0] r_k;

    // Clear wins over enable so a phase change restarts the count on its last increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
        end else if (i_clr) begin
            r_k <= '0;
        end else if (i_en) begin
            r_k <= r_k + 4'd1;
        end
    end

    assign o_k    = r_k;
    assign o_last = (r_k == 4'(NWORDS - 1));

endmodule

// File: rtl/minv_seq.sv
// rtl/minv_seq.sv - host-side load/start/wait/unload sequencer for the 256-bit modular-inverse core
module minv_seq #(
    parameter int W       = minv_pkg::W,
    parameter int DW      = minv_pkg::DW,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_p,
    input  logic          in_newp,
    output logic [DW-1:0] datain,
    output logic          loada,
    output logic          loadp,
    output logic          minv_en,
    output logic          outx1,
    output logic          outx2,
    output logic          outt,
    input  logic [DW-1:0] regx1out,
    input  logic [DW-1:0] regx2out,
    input  logic [DW-1:0] regtout_16,
    input  logic          minv_rdy,
    input  logic [1:0]    minv_flag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_inv,
    output logic          out_err
);
    import minv_pkg::*;

    localparam int             WCW   = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

    minv_seq_state_t r_state, w_state_nxt;

    logic [W-1:0]   r_a, r_p, r_res, r_out_inv, w_res_nxt;
    logic [1:0]     r_flag, w_flag_nxt;
    logic [WCW-1:0] r_wcnt;
    logic [DW-1:0]  r_datain, w_datain_nxt, w_word;
    logic [3:0]     w_k, w_kp1;
    logic           w_k_last;
    logic           w_cnt_clr, w_cnt_en, w_wcnt_clr, w_wcnt_en;
    logic           w_flag_ld, w_ops_ld, w_shift, w_err_set;
    logic           r_loada, r_loadp, r_minv_en, r_outx1, r_outx2, r_outt;
    logic           r_out_valid, r_out_err;

    minv_word_cnt u_word_cnt (
        .clk    (clk),
        .rst_n  (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_k    (w_k),
        .o_last (w_k_last)
    );

    assign w_kp1      = w_k + 4'd1;
    assign w_flag_nxt = w_flag_ld ? minv_flag : r_flag;
    assign w_res_nxt  = w_shift ? {w_word, r_res[W-1:DW]} : r_res;

    // Low word of whichever core result register the latched flag points at
    always_comb begin
        case (r_flag)
            FLAG_X1: w_word = regx1out;
            FLAG_X2: w_word = regx2out;
            default: w_word = regtout_16;
        endcase
    end

    // State register; reset mid-operation simply abandons the core
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counter controls and the next serial word
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        w_wcnt_clr   = 1'b0;
        w_wcnt_en    = 1'b0;
        w_flag_ld    = 1'b0;
        w_ops_ld     = 1'b0;
        w_shift      = 1'b0;
        w_err_set    = 1'b0;
        w_datain_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_ops_ld     = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_nxt  = in_newp ? S_LOADP : S_LOADA;
                    w_datain_nxt = in_newp ? in_p[DW-1:0] : in_a[DW-1:0];
                end
            end
            S_LOADP: begin
                w_cnt_en = 1'b1;
                if (w_k_last) begin
                    w_cnt_clr    = 1'b1;
                    w_state_nxt  = S_LOADA;
                    w_datain_nxt = r_a[DW-1:0];
                end else begin
                    w_datain_nxt = r_p[int'(w_kp1) * DW +: DW];
                end
            end
            S_LOADA: begin
                w_cnt_en = 1'b1;
                if (w_k_last) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_START;
                end else begin
                    w_datain_nxt = r_a[int'(w_kp1) * DW +: DW];
                end
            end
            S_START: begin
                w_wcnt_clr  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_wcnt_en = 1'b1;
                // The first WAIT cycle may still see ready left over from the previous op
                if (minv_rdy && (r_wcnt != '0)) begin
                    w_flag_ld = 1'b1;
                    if (minv_flag == 2'b10) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_UNLOAD;
                    end
                end else if (r_wcnt == WLAST) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_UNLOAD: begin
                w_cnt_en = 1'b1;
                w_shift  = 1'b1;
                if (w_k_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latches, result shift register, flag latch and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a    <= '0;
            r_p    <= '0;
            r_res  <= '0;
            r_flag <= '0;
            r_wcnt <= '0;
        end else begin
            if (w_ops_ld) begin
                r_a <= in_a;
                r_p <= in_p;
            end
            r_res  <= w_ops_ld ? '0 : w_res_nxt;
            r_flag <= w_flag_nxt;
            if (w_wcnt_clr) begin
                r_wcnt <= '0;
            end else if (w_wcnt_en) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    // Registered outputs decoded from the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_datain    <= '0;
            r_loadp     <= 1'b0;
            r_loada     <= 1'b0;
            r_minv_en   <= 1'b0;
            r_outx1     <= 1'b0;
            r_outx2     <= 1'b0;
            r_outt      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_inv   <= '0;
        end else begin
            r_datain    <= w_datain_nxt;
            r_loadp     <= (w_state_nxt == S_LOADP);
            r_loada     <= (w_state_nxt == S_LOADA);
            r_minv_en   <= (w_state_nxt == S_START);
            r_outx1     <= (w_state_nxt == S_UNLOAD) && (w_flag_nxt == FLAG_X1);
            r_outx2     <= (w_state_nxt == S_UNLOAD) && (w_flag_nxt == FLAG_X2);
            r_outt      <= (w_state_nxt == S_UNLOAD) && (w_flag_nxt == FLAG_T);
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_state_nxt != S_DONE) begin
                r_out_err <= 1'b0;
                r_out_inv <= '0;
            end else if (r_state != S_DONE) begin
                r_out_err <= w_err_set;
                r_out_inv <= w_err_set ? '0 : w_res_nxt;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign datain    = r_datain;
    assign loadp     = r_loadp;
    assign loada     = r_loada;
    assign minv_en   = r_minv_en;
    assign outx1     = r_outx1;
    assign outx2     = r_outx2;
    assign outt      = r_outt;
    assign out_valid = r_out_valid;
    assign out_err   = r_out_err;
    assign out_inv   = r_out_inv;

endmodule

// File: tb/tb_minv_seq.sv
// tb/tb_minv_seq.sv - directed self-checking bench for minv_seq with a small core model
module tb_minv_seq;

    localparam int W  = 256;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_p = '0;
    logic          in_newp = 1'b0;
    logic [DW-1:0] datain;
    logic          loada, loadp, minv_en, outx1, outx2, outt;
    logic [DW-1:0] regx1out = '0;
    logic [DW-1:0] regx2out = '0;
    logic [DW-1:0] regtout_16 = '0;
    logic          minv_rdy = 1'b0;
    logic [1:0]    minv_flag = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_inv;
    logic          out_err;

    minv_seq #(.W(W), .DW(DW), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_p       (in_p),
        .in_newp    (in_newp),
        .datain     (datain),
        .loada      (loada),
        .loadp      (loadp),
        .minv_en    (minv_en),
        .outx1      (outx1),
        .outx2      (outx2),
        .outt       (outt),
        .regx1out   (regx1out),
        .regx2out   (regx2out),
        .regtout_16 (regtout_16),
        .minv_rdy   (minv_rdy),
        .minv_flag  (minv_flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inv    (out_inv),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // core model settings, written only by the stimulus process
    logic [W-1:0] m_res = '0;
    int           m_delay = 2;
    bit           m_never = 1'b0;
    bit           m_stale = 1'b0;

    // monitor counters and core model state, written only at the falling edge
    int            c_loadp = 0, c_loada = 0, c_en = 0, c_x1 = 0, c_x2 = 0, c_t = 0, c_bad = 0;
    logic [DW-1:0] p_words [0:511];
    logic [DW-1:0] a_words [0:511];
    bit            armed = 1'b0;
    int            wc = 0;
    int            uidx = 0;

    always @(negedge clk) begin
        if (loadp) begin
            if (c_loadp < 512) p_words[c_loadp] = datain;
            c_loadp++;
        end
        if (loada) begin
            if (c_loada < 512) a_words[c_loada] = datain;
            c_loada++;
        end
        if (!loadp && !loada && datain != '0) c_bad++;
        if (minv_en) c_en++;
        if (outx1) c_x1++;
        if (outx2) c_x2++;
        if (outt)  c_t++;
        if (minv_en) begin
            armed = 1'b1;
            wc = 0;
            uidx = 0;
            minv_rdy = 1'b0;
        end else if (armed) begin
            if (outx1 || outx2 || outt || out_valid) begin
                armed = 1'b0;
                minv_rdy = 1'b0;
            end else begin
                wc++;
                minv_rdy = (!m_never && wc >= m_delay) || (m_stale && wc == 1);
            end
        end
        regx1out   = (outx1 && uidx < 16) ? m_res[uidx*DW +: DW] : 16'hBAD1;
        regx2out   = (outx2 && uidx < 16) ? m_res[uidx*DW +: DW] : 16'hBAD2;
        regtout_16 = (outt  && uidx < 16) ? m_res[uidx*DW +: DW] : 16'hBAD3;
        if (outx1 || outx2 || outt) uidx++;
    end

    int acc = 0;
    int b_loadp, b_loada, b_en, b_x1, b_x2, b_t, b_bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input bit newp, input logic [W-1:0] a, input logic [W-1:0] p,
                            input logic [1:0] flag, input logic [W-1:0] res, input int delay,
                            input bit never, input bit stale);
        int n;
        m_res = res; m_delay = delay; m_never = never; m_stale = stale; minv_flag = flag;
        b_loadp = c_loadp; b_loada = c_loada; b_en = c_en;
        b_x1 = c_x1; b_x2 = c_x2; b_t = c_t; b_bad = c_bad;
        in_a = a; in_p = p; in_newp = newp; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", W'(in_ready), W'(1));
        tick();
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        check("out_valid_seen", W'(out_valid), W'(1));
        lat = cyc - acc;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_xfer", W'({in_ready, out_valid}), W'(2'b10));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int bad;
        logic [W-1:0] a2, res2, res_a, res_b;

        for (int i = 0; i < 16; i++) a2[i*DW +: DW] = DW'(16'h1000 + i);
        res2  = {{15{16'hFFFF}}, 16'h0001};
        res_a = {16'h0F0F, 224'h0, 16'h1234};
        res_b = 256'hCAFE_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_BEEF_0042;

        // reset state
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_outs", W'({datain, loada, loadp, minv_en, outx1, outx2, outt, out_valid, out_err}), W'(0));
        check("rst_inv", out_inv, W'(0));

        // full operation with a new modulus, result 5 in x1
        start_op(1'b1, W'(3), W'(7), 2'b00, W'(5), 3, 1'b0, 1'b0);
        wait_valid(lat);
        check("t1_lat", W'(lat), W'(52));
        check("t1_inv", out_inv, W'(5));
        check("t1_err", W'(out_err), W'(0));
        check("t1_nloadp", W'(c_loadp - b_loadp), W'(16));
        check("t1_nloada", W'(c_loada - b_loada), W'(16));
        check("t1_pw0", W'(p_words[b_loadp]), W'(7));
        check("t1_aw0", W'(a_words[b_loada]), W'(3));
        bad = 0;
        for (int i = 1; i < 16; i++) begin
            if (p_words[b_loadp + i] != '0) bad++;
            if (a_words[b_loada + i] != '0) bad++;
        end
        check("t1_upper_words", W'(bad), W'(0));
        check("t1_en_pulses", W'(c_en - b_en), W'(1));
        check("t1_outx1_cycles", W'(c_x1 - b_x1), W'(16));
        check("t1_other_strobes", W'((c_x2 - b_x2) + (c_t - b_t)), W'(0));
        check("t1_datain_idle", W'(c_bad - b_bad), W'(0));
        release_out();

        // reuse modulus, result in t, then hold off the consumer for 10 cycles
        start_op(1'b0, a2, W'(256'hDEAD), 2'b11, res2, 2, 1'b0, 1'b0);
        wait_valid(lat);
        check("t2_lat", W'(lat), W'(35));
        check("t2_inv", out_inv, res2);
        check("t2_err", W'(out_err), W'(0));
        check("t2_nloadp", W'(c_loadp - b_loadp), W'(0));
        check("t2_nloada", W'(c_loada - b_loada), W'(16));
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_words[b_loada + i] != DW'(16'h1000 + i)) bad++;
        end
        check("t2_a_words", W'(bad), W'(0));
        check("t2_outt_cycles", W'(c_t - b_t), W'(16));
        check("t2_other_strobes", W'((c_x1 - b_x1) + (c_x2 - b_x2)), W'(0));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_inv !== res2 || in_ready) bad++;
        end
        check("t2_backpressure_hold", W'(bad), W'(0));
        release_out();

        // illegal flag 10
        start_op(1'b0, W'(256'h11), W'(0), 2'b10, W'(256'h1234), 2, 1'b0, 1'b0);
        wait_valid(lat);
        check("t3_lat", W'(lat), W'(19));
        check("t3_err", W'(out_err), W'(1));
        check("t3_inv", out_inv, W'(0));
        check("t3_no_unload", W'((c_x1 - b_x1) + (c_x2 - b_x2) + (c_t - b_t)), W'(0));
        release_out();

        // timeout with a stale ready in the first WAIT cycle
        start_op(1'b0, W'(256'h22), W'(0), 2'b00, W'(256'h77), 2, 1'b1, 1'b1);
        wait_valid(lat);
        check("t4_lat", W'(lat), W'(25));
        check("t4_err", W'(out_err), W'(1));
        check("t4_inv", out_inv, W'(0));
        check("t4_no_unload", W'((c_x1 - b_x1) + (c_x2 - b_x2) + (c_t - b_t)), W'(0));
        release_out();

        // reset during UNLOAD at k = 7, then a clean operation
        start_op(1'b1, W'(256'h5), W'(256'hB), 2'b01, res_a, 2, 1'b0, 1'b0);
        bad = 0;
        while (!(outx2 && (c_x2 - b_x2) == 7) && bad < 300) begin
            tick();
            bad++;
        end
        check("t5_reached_k7", W'(c_x2 - b_x2), W'(7));
        rst = 1'b0;
        #1;
        check("t5_async_outs", W'({datain, loada, loadp, minv_en, outx1, outx2, outt, out_valid, out_err}), W'(0));
        check("t5_async_inv", out_inv, W'(0));
        check("t5_in_ready", W'(in_ready), W'(1));
        tick();
        rst = 1'b1;
        tick();
        start_op(1'b1, W'(256'h9), W'(256'hD), 2'b00, res_b, 4, 1'b0, 1'b0);
        wait_valid(lat);
        check("t5_lat", W'(lat), W'(53));
        check("t5_inv", out_inv, res_b);
        check("t5_err", W'(out_err), W'(0));
        release_out();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/minv_seq.md
# minv_seq

Host-side sequencer for the 256-bit modular-inverse core, placed between the host's parallel datapath and the core's 16-bit serial port. It accepts a parallel operand `a` (and, optionally, a new modulus `p`) over a valid/ready handshake and streams them into the core 16 bits per cycle. It then pulses `minv_en`, waits for `minv_rdy`, and uses `minv_flag` to select which core result register to unload. It reassembles the 256-bit inverse and returns it over a second valid/ready handshake, with an error flag.

## Interface
- `W`, 256, operand/result width
- `DW`, 16, serial word width; `W/DW` = 16 words
- `TIMEOUT`, 4096, max WAIT cycles before abort
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand request valid
- `in_ready`  out  1  high only in IDLE
- `in_a`  in  W  operand to invert
- `in_p`  in  W  modulus
- `in_newp`  in  1  1 = load `in_p` before `a`; 0 = reuse the modulus already in the core
- `datain`  out  DW  serial word to core
- `loada`, `loadp`, `minv_en`, `outx1`, `outx2`, `outt`  out  1 each  core strobes
- `regx1out`, `regx2out`, `regtout_16`  in  DW  core result low words
- `minv_rdy`  in  1  core completion (level)
- `minv_flag`  in  2  result location: 00 = x1, 01 = x2, 11 = t, 10 = illegal
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts
- `out_inv`  out  W  inverse
- `out_err`  out  1  1 = timeout or illegal flag; `out_inv` = 0

## Operation
- FSM states: IDLE, LOADP, LOADA, START, WAIT, UNLOAD, DONE; 4-bit word counter `k`.
- IDLE: `in_ready` = 1. On `in_valid` the block latches `a`, `p`, and `newp`; next state is LOADP if `newp`, else LOADA; `k` = 0.
- LOADP: `loadp` = 1, `datain` = `p[16k+15:16k]`, least-significant word first. After `k` = 15 → LOADA, `k` = 0.
- LOADA: same as LOADP with `loada` = 1 and operand `a`. After `k` = 15 → START.
- START: `minv_en` = 1 for exactly one cycle → WAIT; the wait counter clears.
- WAIT: `minv_rdy` is ignored on the first WAIT cycle (stale ready from the previous op). After that, `minv_rdy` = 1 latches `minv_flag`:
  - Flags 00, 01, 11 → UNLOAD with `k` = 0.
  - Flag 10 → DONE with err = 1.
  - If the wait counter reaches `TIMEOUT` → DONE with err = 1.
- UNLOAD: exactly one of `outx1`/`outx2`/`outt` is held high per the latched flag for 16 cycles. Each cycle the block samples the selected low word before the edge and shifts it into the top of the result register (`res <= {word, res[W-1:DW]}`). After `k` = 15 → DONE.
- DONE: `out_valid` = 1; `out_inv`/`out_err` are stable until `out_ready`, then → IDLE.
- All core strobes are 0 outside their own states; `datain` = 0 when no load strobe is active.
- On an error, `out_inv` = 0.

## Timing
- Reset (async, `rst` = 0): state IDLE, `in_ready` = 1 after release. All other outputs are 0, including `out_valid`, `out_err`, `out_inv`, `datain`, and all strobes. Latched operands are cleared.
- Reset mid-operation aborts immediately. The core is not informed; the next request must set `in_newp` = 1.
- All outputs are registered except `in_ready`, which is decoded from the state.
- Latency with `newp`, accept edge = cycle 0:
  - LOADP: cycles 1–16
  - LOADA: cycles 17–32
  - START: cycle 33
  - WAIT: from cycle 34
  - `minv_rdy` seen in cycle N → UNLOAD cycles N+1..N+16
  - `out_valid` from N+17
- Without `newp`, every stage from LOADA onward is 16 cycles earlier.
- `out_valid` and `out_ready` high in the same cycle: the transfer completes and the block is in IDLE the next cycle. A new request cannot be accepted in that same cycle.
- Simultaneous `minv_rdy` = 1 and timeout in WAIT: `minv_rdy` wins.

## Structure
- Package `minv_pkg`: `W`/`DW`/`NWORDS` constants, state enum `minv_seq_state_t`, flag codes `FLAG_X1` = 2'b00, `FLAG_X2` = 2'b01, `FLAG_T` = 2'b11.
- One sub-module, `minv_word_cnt`: 4-bit counter with clear, enable, and a terminal (`k` = 15) output. It is shared by LOADP, LOADA, and UNLOAD.
- The wait counter is inline, `$clog2(TIMEOUT+1)` bits wide.

## Test plan
- Full op: `newp` = 1, `a` = 3, `p` = 7, and the core model returns 5 in x1 (flag 00) → 16 `loadp` words then 16 `loada` words, with words 0 = 7 and 3 respectively and the rest 0; one `minv_en` pulse; `outx1` high exactly 16 cycles; `out_inv` = 5, `out_err` = 0.
- Reuse modulus: `newp` = 0, flag 11, result `0xFFFF…0001` → no `loadp` cycles, `outt` strobed, `out_inv` = `0xFFFF…0001`; latency 16 cycles shorter.
- Backpressure: `out_ready` = 0 for 10 cycles → `out_valid` held and `out_inv` stable; `in_ready` = 0 until the cycle after acceptance.
- Illegal flag 10 at `minv_rdy` → no `out*` strobes, `out_valid` with `out_err` = 1 and `out_inv` = 0.
- Timeout: `TIMEOUT` = 8 and the core never asserts ready → DONE after 8 WAIT cycles with `out_err` = 1. A stale `minv_rdy` = 1 in the first WAIT cycle is ignored.
- Assert `rst` = 0 during UNLOAD at `k` = 7 → all outputs 0 asynchronously; after release `in_ready` = 1 and the next op completes correctly.
